// File: rtl/multicycle_control_unit_if.sv
// Control bundle between the multi-cycle MIPS control FSM and its datapath.
// The control unit is the master: it consumes instruction fields and the zero flag and drives every select/strobe.
interface multicycle_control_unit_if #(
  parameter int ALU_OP_W = 4,
  parameter int STATE_W  = 4
);
  logic [5:0]          opcode_i;
  logic [5:0]          funct_i;
  logic                zero_i;
  logic [ALU_OP_W-1:0] alu_operation_o;
  logic                alu_src_a_o;
  logic [1:0]          alu_src_b_o;
  logic                zero_extend_o;
  logic                iord_o;
  logic                mem_read_o;
  logic                mem_write_o;
  logic                ir_write_o;
  logic                reg_dst_o;
  logic                mem_to_reg_o;
  logic                reg_write_o;
  logic [1:0]          pc_source_o;
  logic                pc_en_o;
  logic                illegal_o;
  logic [STATE_W-1:0]  state_o;

  modport master (
    input  opcode_i, funct_i, zero_i,
    output alu_operation_o, alu_src_a_o, alu_src_b_o, zero_extend_o, iord_o,
           mem_read_o, mem_write_o, ir_write_o, reg_dst_o, mem_to_reg_o,
           reg_write_o, pc_source_o, pc_en_o, illegal_o, state_o
  );

  modport slave (
    output opcode_i, funct_i, zero_i,
    input  alu_operation_o, alu_src_a_o, alu_src_b_o, zero_extend_o, iord_o,
           mem_read_o, mem_write_o, ir_write_o, reg_dst_o, mem_to_reg_o,
           reg_write_o, pc_source_o, pc_en_o, illegal_o, state_o
  );
endinterface

// File: rtl/multicycle_control_unit.sv
// Moore control FSM for the multi-cycle MIPS datapath (lw, sw, add, sub, or, addi, ori, beq, j).
// Unsupported encodings park in ILLEGAL until reset; only the BRANCH pc_en follows zero_i combinationally.
module multicycle_control_unit #(
  parameter int ALU_OP_W = 4,
  parameter int STATE_W  = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  multicycle_control_unit_if.master ctrl_bus
);

  typedef enum logic [STATE_W-1:0] {
    S_IDLE      = STATE_W'(0),
    S_FETCH     = STATE_W'(1),
    S_DECODE    = STATE_W'(2),
    S_MEM_ADDR  = STATE_W'(3),
    S_MEM_READ  = STATE_W'(4),
    S_MEM_WB    = STATE_W'(5),
    S_MEM_WRITE = STATE_W'(6),
    S_R_EXEC    = STATE_W'(7),
    S_R_WB      = STATE_W'(8),
    S_I_EXEC    = STATE_W'(9),
    S_I_WB      = STATE_W'(10),
    S_BRANCH    = STATE_W'(11),
    S_JUMP      = STATE_W'(12),
    S_ILLEGAL   = STATE_W'(13)
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_OR  = 6'b100101;

  localparam logic [ALU_OP_W-1:0] ALU_NONE = ALU_OP_W'(4'b0000);
  localparam logic [ALU_OP_W-1:0] ALU_OR   = ALU_OP_W'(4'b0010);
  localparam logic [ALU_OP_W-1:0] ALU_ADD  = ALU_OP_W'(4'b0011);
  localparam logic [ALU_OP_W-1:0] ALU_SUB  = ALU_OP_W'(4'b0100);

  localparam logic [1:0] SRC_B_REG   = 2'b00;
  localparam logic [1:0] SRC_B_FOUR  = 2'b01;
  localparam logic [1:0] SRC_B_IMM   = 2'b10;
  localparam logic [1:0] SRC_B_IMMX4 = 2'b11;

  localparam logic [1:0] PC_SRC_ALU     = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT  = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP    = 2'b10;

  state_t              r_state;
  state_t              w_state_next;
  logic [5:0]          r_opcode;

  logic [ALU_OP_W-1:0] w_alu_operation;
  logic                w_alu_src_a;
  logic [1:0]          w_alu_src_b;
  logic                w_zero_extend;
  logic                w_iord;
  logic                w_mem_read;
  logic                w_mem_write;
  logic                w_ir_write;
  logic                w_reg_dst;
  logic                w_mem_to_reg;
  logic                w_reg_write;
  logic [1:0]          w_pc_source;
  logic                w_pc_en;
  logic                w_illegal;

  function automatic logic is_legal_funct(input logic [5:0] funct);
    return funct inside {FN_ADD, FN_SUB, FN_OR};
  endfunction

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // The opcode is captured in DECODE so MEM_ADDR and I_EXEC ignore later changes on the IR bus.
  // NOTE: no reset here; r_opcode is only read in states that are always entered through DECODE.
  always_ff @(posedge clk) begin
    if (r_state == S_DECODE) begin
      r_opcode <= ctrl_bus.opcode_i;
    end
  end

  // NOTE: the default assignment at the top keeps this block free of inferred latches.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:     w_state_next = S_FETCH;
      S_FETCH:    w_state_next = S_DECODE;
      S_DECODE: begin
        case (ctrl_bus.opcode_i)
          OP_LW, OP_SW:    w_state_next = S_MEM_ADDR;
          OP_RTYPE:        w_state_next = is_legal_funct(ctrl_bus.funct_i) ? S_R_EXEC : S_ILLEGAL;
          OP_ADDI, OP_ORI: w_state_next = S_I_EXEC;
          OP_BEQ:          w_state_next = S_BRANCH;
          OP_J:            w_state_next = S_JUMP;
          default:         w_state_next = S_ILLEGAL;
        endcase
      end
      S_MEM_ADDR:  w_state_next = (r_opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ:  w_state_next = S_MEM_WB;
      S_MEM_WB:    w_state_next = S_FETCH;
      S_MEM_WRITE: w_state_next = S_FETCH;
      S_R_EXEC:    w_state_next = S_R_WB;
      S_R_WB:      w_state_next = S_FETCH;
      S_I_EXEC:    w_state_next = S_I_WB;
      S_I_WB:      w_state_next = S_FETCH;
      S_BRANCH:    w_state_next = S_FETCH;
      S_JUMP:      w_state_next = S_FETCH;
      S_ILLEGAL:   w_state_next = S_ILLEGAL;
      default:     w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_alu_operation = ALU_NONE;
    w_alu_src_a     = 1'b0;
    w_alu_src_b     = SRC_B_REG;
    w_zero_extend   = 1'b0;
    w_iord          = 1'b0;
    w_mem_read      = 1'b0;
    w_mem_write     = 1'b0;
    w_ir_write      = 1'b0;
    w_reg_dst       = 1'b0;
    w_mem_to_reg    = 1'b0;
    w_reg_write     = 1'b0;
    w_pc_source     = PC_SRC_ALU;
    w_pc_en         = 1'b0;
    w_illegal       = 1'b0;

    case (r_state)
      S_FETCH: begin
        w_mem_read      = 1'b1;
        w_ir_write      = 1'b1;
        w_alu_src_b     = SRC_B_FOUR;
        w_alu_operation = ALU_ADD;
        w_pc_en         = 1'b1;
      end
      S_DECODE: begin
        w_alu_src_b     = SRC_B_IMMX4;
        w_alu_operation = ALU_ADD;
      end
      S_MEM_ADDR: begin
        w_alu_src_a     = 1'b1;
        w_alu_src_b     = SRC_B_IMM;
        w_alu_operation = ALU_ADD;
      end
      S_MEM_READ: begin
        w_mem_read = 1'b1;
        w_iord     = 1'b1;
      end
      S_MEM_WB: begin
        w_reg_write  = 1'b1;
        w_mem_to_reg = 1'b1;
      end
      S_MEM_WRITE: begin
        w_mem_write = 1'b1;
        w_iord      = 1'b1;
      end
      S_R_EXEC: begin
        w_alu_src_a = 1'b1;
        case (ctrl_bus.funct_i)
          FN_ADD:  w_alu_operation = ALU_ADD;
          FN_SUB:  w_alu_operation = ALU_SUB;
          FN_OR:   w_alu_operation = ALU_OR;
          default: w_alu_operation = ALU_NONE;
        endcase
      end
      S_R_WB: begin
        w_reg_write = 1'b1;
        w_reg_dst   = 1'b1;
      end
      S_I_EXEC: begin
        w_alu_src_a = 1'b1;
        w_alu_src_b = SRC_B_IMM;
        if (r_opcode == OP_ORI) begin
          w_alu_operation = ALU_OR;
          w_zero_extend   = 1'b1;
        end else begin
          w_alu_operation = ALU_ADD;
        end
      end
      S_I_WB: begin
        w_reg_write = 1'b1;
      end
      S_BRANCH: begin
        w_alu_src_a     = 1'b1;
        w_alu_operation = ALU_SUB;
        w_pc_source     = PC_SRC_ALUOUT;
        w_pc_en         = ctrl_bus.zero_i;
      end
      S_JUMP: begin
        w_pc_source = PC_SRC_JUMP;
        w_pc_en     = 1'b1;
      end
      S_ILLEGAL: begin
        w_illegal = 1'b1;
      end
      default: ;
    endcase

    // Reset gates every strobe immediately so an aborted instruction never writes anything.
    if (reset) begin
      w_mem_read  = 1'b0;
      w_mem_write = 1'b0;
      w_ir_write  = 1'b0;
      w_reg_write = 1'b0;
      w_pc_en     = 1'b0;
    end
  end

  assign ctrl_bus.alu_operation_o = w_alu_operation;
  assign ctrl_bus.alu_src_a_o     = w_alu_src_a;
  assign ctrl_bus.alu_src_b_o     = w_alu_src_b;
  assign ctrl_bus.zero_extend_o   = w_zero_extend;
  assign ctrl_bus.iord_o          = w_iord;
  assign ctrl_bus.mem_read_o      = w_mem_read;
  assign ctrl_bus.mem_write_o     = w_mem_write;
  assign ctrl_bus.ir_write_o      = w_ir_write;
  assign ctrl_bus.reg_dst_o       = w_reg_dst;
  assign ctrl_bus.mem_to_reg_o    = w_mem_to_reg;
  assign ctrl_bus.reg_write_o     = w_reg_write;
  assign ctrl_bus.pc_source_o     = w_pc_source;
  assign ctrl_bus.pc_en_o         = w_pc_en;
  assign ctrl_bus.illegal_o       = w_illegal;
  assign ctrl_bus.state_o         = r_state;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench for multicycle_control_unit: directed instruction sequences, then random instructions,
// random mid-instruction resets and garbage on opcode/funct/zero in cycles where they must be ignored.
module tb_multicycle_control_unit;

  localparam int ALU_OP_W = 4;
  localparam int STATE_W  = 4;

  localparam int ST_IDLE = 0,  ST_FETCH = 1,  ST_DECODE = 2,  ST_MEM_ADDR = 3, ST_MEM_READ = 4;
  localparam int ST_MEM_WB = 5, ST_MEM_WRITE = 6, ST_R_EXEC = 7, ST_R_WB = 8,  ST_I_EXEC = 9;
  localparam int ST_I_WB = 10, ST_BRANCH = 11, ST_JUMP = 12, ST_ILLEGAL = 13;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000, ADDI = 6'b001000;
  localparam logic [5:0] ORI = 6'b001101, BEQ = 6'b000100, JMP = 6'b000010;
  localparam logic [5:0] F_ADD = 6'b100000, F_SUB = 6'b100010, F_OR = 6'b100101;

  typedef struct packed {
    logic [3:0] alu;
    logic       src_a;
    logic [1:0] src_b;
    logic       zext;
    logic       iord;
    logic       mr;
    logic       mw;
    logic       irw;
    logic       reg_dst;
    logic       m2r;
    logic       rw;
    logic [1:0] pc_src;
    logic       pc_en;
    logic       ill;
  } out_t;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  multicycle_control_unit_if #(.ALU_OP_W(ALU_OP_W), .STATE_W(STATE_W)) bus ();

  multicycle_control_unit #(.ALU_OP_W(ALU_OP_W), .STATE_W(STATE_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .ctrl_bus (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic out_t observe();
    out_t o;
    o.alu     = bus.alu_operation_o;
    o.src_a   = bus.alu_src_a_o;
    o.src_b   = bus.alu_src_b_o;
    o.zext    = bus.zero_extend_o;
    o.iord    = bus.iord_o;
    o.mr      = bus.mem_read_o;
    o.mw      = bus.mem_write_o;
    o.irw     = bus.ir_write_o;
    o.reg_dst = bus.reg_dst_o;
    o.m2r     = bus.mem_to_reg_o;
    o.rw      = bus.reg_write_o;
    o.pc_src  = bus.pc_source_o;
    o.pc_en   = bus.pc_en_o;
    o.ill     = bus.illegal_o;
    return o;
  endfunction

  // Reference table of what each step of an instruction must drive.
  function automatic out_t expect_out(input int st, input logic [5:0] op, input logic [5:0] fn,
                                      input logic z, input logic rst);
    out_t e = '0;
    case (st)
      ST_FETCH:     begin e.mr = 1; e.irw = 1; e.src_b = 2'b01; e.alu = 4'b0011; e.pc_en = 1; end
      ST_DECODE:    begin e.src_b = 2'b11; e.alu = 4'b0011; end
      ST_MEM_ADDR:  begin e.src_a = 1; e.src_b = 2'b10; e.alu = 4'b0011; end
      ST_MEM_READ:  begin e.mr = 1; e.iord = 1; end
      ST_MEM_WB:    begin e.rw = 1; e.m2r = 1; end
      ST_MEM_WRITE: begin e.mw = 1; e.iord = 1; end
      ST_R_EXEC: begin
        e.src_a = 1;
        e.alu = (fn == F_ADD) ? 4'b0011 : (fn == F_SUB) ? 4'b0100 : (fn == F_OR) ? 4'b0010 : 4'b0000;
      end
      ST_R_WB:   begin e.rw = 1; e.reg_dst = 1; end
      ST_I_EXEC: begin
        e.src_a = 1; e.src_b = 2'b10;
        if (op == ORI) begin e.alu = 4'b0010; e.zext = 1; end
        else e.alu = 4'b0011;
      end
      ST_I_WB:    e.rw = 1;
      ST_BRANCH:  begin e.src_a = 1; e.alu = 4'b0100; e.pc_src = 2'b01; e.pc_en = z; end
      ST_JUMP:    begin e.pc_src = 2'b10; e.pc_en = 1; end
      ST_ILLEGAL: e.ill = 1;
      default: ;
    endcase
    if (rst) begin
      e.mr = 0; e.mw = 0; e.irw = 0; e.rw = 0; e.pc_en = 0;
    end
    return e;
  endfunction

  task automatic randomize_inputs();
    bus.opcode_i = 6'($urandom);
    bus.funct_i  = 6'($urandom);
    bus.zero_i   = 1'($urandom);
  endtask

  // Hold reset for n cycles starting from state st, then one release cycle that must sit in IDLE.
  task automatic do_reset(input int n, input int st, input logic [5:0] op);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      reset = 1'b1;
      randomize_inputs();
      #1;
      check("rst_state", 32'(bus.state_o), 32'((i == 0) ? st : ST_IDLE));
      check("rst_outs", 32'(observe()),
            32'(expect_out((i == 0) ? st : ST_IDLE, op, bus.funct_i, bus.zero_i, 1'b1)));
    end
    @(negedge clk);
    reset = 1'b0;
    randomize_inputs();
    #1;
    check("idle_state", 32'(bus.state_o), 32'(ST_IDLE));
    check("idle_outs", 32'(observe()), 32'(expect_out(ST_IDLE, op, bus.funct_i, bus.zero_i, 1'b0)));
  endtask

  // Run one instruction from FETCH; stop_at >= 0 cuts it short at that step for a reset.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                           input int n_ill, input int stop_at, output bit stopped, output int last_st);
    int seq[$];
    seq = {ST_FETCH, ST_DECODE};
    if (op == LW)                               seq = {seq, ST_MEM_ADDR, ST_MEM_READ, ST_MEM_WB};
    else if (op == SW)                          seq = {seq, ST_MEM_ADDR, ST_MEM_WRITE};
    else if (op == RT && fn inside {F_ADD, F_SUB, F_OR}) seq = {seq, ST_R_EXEC, ST_R_WB};
    else if (op == ADDI || op == ORI)           seq = {seq, ST_I_EXEC, ST_I_WB};
    else if (op == BEQ)                         seq = {seq, ST_BRANCH};
    else if (op == JMP)                         seq = {seq, ST_JUMP};
    else for (int k = 0; k < n_ill; k++)        seq.push_back(ST_ILLEGAL);
    stopped = 1'b0;
    last_st = ST_FETCH;
    for (int i = 0; i < seq.size(); i++) begin
      if (i == stop_at) begin
        stopped = 1'b1;
        last_st = seq[i];
        return;
      end
      @(negedge clk);
      reset = 1'b0;
      randomize_inputs();
      if (seq[i] == ST_DECODE) bus.opcode_i = op;
      if (seq[i] == ST_DECODE || seq[i] == ST_R_EXEC) bus.funct_i = fn;
      if (seq[i] == ST_BRANCH) bus.zero_i = z;
      #1;
      check("state", 32'(bus.state_o), 32'(seq[i]));
      check("outs", 32'(observe()), 32'(expect_out(seq[i], op, bus.funct_i, bus.zero_i, 1'b0)));
    end
  endtask

  task automatic run_full(input logic [5:0] op, input logic [5:0] fn, input logic z);
    bit stopped;
    int st;
    run_instr(op, fn, z, 0, -1, stopped, st);
  endtask

  initial begin
    bit          stopped;
    int          st;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic        z;
    logic [5:0]  funct_pick [3];

    funct_pick[0] = F_ADD;
    funct_pick[1] = F_SUB;
    funct_pick[2] = F_OR;

    reset = 1'b1;
    bus.opcode_i = LW;
    bus.funct_i  = '0;
    bus.zero_i   = 1'b0;
    do_reset(3, ST_IDLE, LW);

    run_full(LW, 6'd0, 1'b0);
    run_full(RT, F_SUB, 1'b0);
    run_full(ORI, 6'd5, 1'b0);
    run_full(ADDI, 6'd9, 1'b0);
    run_full(BEQ, 6'd0, 1'b1);
    run_full(BEQ, 6'd0, 1'b0);
    run_full(JMP, 6'd0, 1'b1);
    run_full(SW, 6'd0, 1'b0);
    run_full(RT, F_ADD, 1'b0);
    run_full(RT, F_OR, 1'b0);

    run_instr(6'b111111, 6'd0, 1'b0, 20, -1, stopped, st);
    do_reset(2, ST_ILLEGAL, 6'b111111);
    run_instr(RT, 6'b000000, 1'b0, 20, -1, stopped, st);
    do_reset(2, ST_ILLEGAL, RT);

    run_instr(LW, 6'd0, 1'b0, 0, 3, stopped, st);
    check("abort_point", 32'(st), 32'(ST_MEM_READ));
    do_reset(1, st, LW);
    run_full(ADDI, 6'd0, 1'b0);

    for (int n = 0; n < 80; n++) begin
      fn = 6'($urandom);
      z  = 1'($urandom);
      case ($urandom_range(0, 8))
        0: op = LW;
        1: op = SW;
        2: begin op = RT; fn = funct_pick[$urandom_range(0, 2)]; end
        3: op = ADDI;
        4: op = ORI;
        5: op = BEQ;
        6: op = JMP;
        7: begin
          do op = 6'($urandom); while (op inside {LW, SW, RT, ADDI, ORI, BEQ, JMP});
        end
        default: begin
          op = RT;
          do fn = 6'($urandom); while (fn inside {F_ADD, F_SUB, F_OR});
        end
      endcase
      run_instr(op, fn, z, int'($urandom_range(1, 5)),
                ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 4)) : -1, stopped, st);
      if (stopped) begin
        do_reset(int'($urandom_range(1, 2)), st, op);
      end else if (!(op inside {LW, SW, ADDI, ORI, BEQ, JMP}) &&
                   !(op == RT && fn inside {F_ADD, F_SUB, F_OR})) begin
        do_reset(2, ST_ILLEGAL, op);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
